scan_mux: RTL and testbench
===========================

SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 35: width of each data channel.
REQ-002 SHALL have parameter CHANNELS, default 8, legal range 2..64: number of input channels.
REQ-003 SHALL have parameter SCAN_DIV, default 4, minimum 1: clock cycles each channel is held in scan mode.
REQ-004 SHALL derive localparam SEL_W = max(1, clog2(CHANNELS)).
REQ-005 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port in_bus, input, CHANNELS*DATA_WIDTH: channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port select, input, SEL_W: channel index used in manual mode.
REQ-009 SHALL have port enable, input, 1: output gate; low forces a zero output.
REQ-010 SHALL have port mode, input, 1: 0 selects manual mode, 1 selects scan mode.
REQ-011 SHALL have port hold, input, 1: freezes scan advance while high.
REQ-012 SHALL have port out, output, DATA_WIDTH: registered selected data.
REQ-013 SHALL have port cur_sel, output, SEL_W: registered index of the channel currently presented on out.
REQ-014 SHALL have port out_valid, output, 1: out holds a legal, enabled channel.
REQ-015 SHALL have port wrap, output, 1: one-cycle pulse marking scan wrap-around.

Function
REQ-016 All outputs SHALL be registered, with exactly one cycle of latency from the sampled inputs to out, cur_sel and out_valid.
REQ-017 In manual mode with enable=1 and select<CHANNELS: out SHALL equal in_bus[select] and cur_sel SHALL equal select, with out_valid=1 on the next cycle.
REQ-018 In manual mode with select>=CHANNELS (non-power-of-2 CHANNELS): out SHALL be 0 and out_valid SHALL be 0, with cur_sel still loaded from select.
REQ-019 With enable=0 in either mode: out SHALL be 0 and out_valid SHALL be 0, while cur_sel and the prescaler keep their normal behaviour.
REQ-020 The scan state machine SHALL have two states, MANUAL and SCAN, with the state following mode on each clock.
REQ-021 On the MANUAL->SCAN transition: cur_sel SHALL be set to 0, the prescaler cleared, and out SHALL present channel 0 on that edge.
REQ-022 In SCAN: the prescaler SHALL count 0..SCAN_DIV-1, and at terminal count cur_sel SHALL advance by 1 and the prescaler reset to 0.
REQ-023 In SCAN: when cur_sel=CHANNELS-1 at terminal count, cur_sel SHALL wrap to 0 and wrap SHALL assert for exactly one cycle, aligned with cur_sel=0.
REQ-024 With SCAN_DIV=1: cur_sel SHALL advance every cycle.
REQ-025 In SCAN with hold=1: the prescaler and cur_sel SHALL freeze, wrap SHALL be 0, and out SHALL continue tracking in_bus[cur_sel] each cycle.
REQ-026 On the SCAN->MANUAL transition: the prescaler SHALL clear and manual selection SHALL apply on that same edge.
REQ-027 In manual mode: wrap SHALL be 0.

Reset
REQ-028 When reset=1 on a clock edge: out SHALL be 0, cur_sel 0, out_valid 0, wrap 0, prescaler 0, and state MANUAL.
REQ-029 reset SHALL take priority over mode, hold and enable, including mid-scan.
REQ-030 Operation SHALL resume on the first edge with reset=0.

Configuration
REQ-031 With macro SCAN_MUX_SCAN_EN defined: scan mode, hold and wrap SHALL behave per REQ-020..REQ-027.
REQ-032 Without SCAN_MUX_SCAN_EN: mode and hold SHALL be ignored, no prescaler logic SHALL be built, wrap SHALL be tied to 0, and behaviour SHALL be manual-only.

Verification
REQ-033 Manual, CHANNELS=8, DATA_WIDTH=35, enable=1, select=5, channel 5=35'h1_2345_6789: next cycle out=35'h1_2345_6789, cur_sel=5, out_valid=1.
REQ-034 Scan, SCAN_DIV=4, CHANNELS=8, from reset, mode=1: cur_sel steps 0..7 every 4 cycles, and wrap is high for one cycle when cur_sel returns to 0 at cycle 32.
REQ-035 CHANNELS=6, manual, select=7: out=0, out_valid=0, cur_sel=7.
REQ-036 Scan with hold=1 for 10 cycles at cur_sel=3: cur_sel stays 3, and on hold release cur_sel advances to 4 after the remaining prescaler cycles.
REQ-037 reset asserted mid-scan at cur_sel=6 with enable=1: next cycle out=0, cur_sel=0, out_valid=0, state MANUAL.
REQ-038 Build without SCAN_MUX_SCAN_EN, mode=1, select=2: out=channel 2, cur_sel=2, wrap never asserts.

Source files
------------

// File: rtl/scan_mux.sv
// scan_mux: registered CHANNELS-way data selector with manual select and optional auto-scan.
// Scan mode, hold and wrap are built only when SCAN_MUX_SCAN_EN is defined; otherwise manual-only.
module scan_mux #(
    parameter int  DATA_WIDTH = 35,
    parameter int  CHANNELS   = 8,
    parameter int  SCAN_DIV   = 4,
    localparam int SEL_W      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]               select,
    input  logic                           enable,
    input  logic                           mode,
    input  logic                           hold,
    output logic [DATA_WIDTH-1:0]          out,
    output logic [SEL_W-1:0]               cur_sel,
    output logic                           out_valid,
    output logic                           wrap
);

    logic [SEL_W-1:0]      sel_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  hit_d;

    // Compare against each legal index so codes past the last channel simply miss.
    always_comb begin
        data_d = '0;
        hit_d  = 1'b0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel_d == SEL_W'(k)) begin
                data_d = in_bus[k*DATA_WIDTH +: DATA_WIDTH];
                hit_d  = 1'b1;
            end
        end
    end

`ifdef SCAN_MUX_SCAN_EN
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        MANUAL,
        SCAN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             wrap_d;

    always_comb begin
        state_d = mode ? SCAN : MANUAL;
        sel_d   = select;
        pre_d   = '0;
        wrap_d  = 1'b0;
        case (state_q)
            MANUAL: begin
                if (mode) begin
                    sel_d = '0;
                end
            end
            SCAN: begin
                if (mode) begin
                    if (hold) begin
                        sel_d = cur_sel;
                        pre_d = pre_q;
                    end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
                        if (cur_sel == SEL_W'(CHANNELS - 1)) begin
                            sel_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = cur_sel + SEL_W'(1);
                        end
                    end else begin
                        sel_d = cur_sel;
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
            end
            default: begin
                sel_d = select;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MANUAL;
            pre_q   <= '0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            wrap    <= wrap_d;
        end
    end
`else
    logic unused_scan_inputs;
    assign unused_scan_inputs = mode ^ hold ^ (SCAN_DIV > 0);
    assign sel_d              = select;
    assign wrap               = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out       <= '0;
            cur_sel   <= '0;
            out_valid <= 1'b0;
        end else begin
            cur_sel   <= sel_d;
            out_valid <= enable && hit_d;
            out       <= (enable && hit_d) ? data_d : '0;
        end
    end

endmodule

// File: tb/tb_scan_mux.sv
// tb_scan_mux: randomized self-checking bench for scan_mux against a behavioural reference model.
// Two instances: 8 x 35-bit (SCAN_DIV=4) and 6 x 8-bit (SCAN_DIV=1, non-power-of-2 channel count).
`timescale 1ns/1ps
module tb_scan_mux;

    localparam int DWA = 35, CHA = 8, DIVA = 4;
    localparam int DWB = 8,  CHB = 6, DIVB = 1;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;
    logic mode   = 1'b0;
    logic hold   = 1'b0;

    logic [CHA*DWA-1:0] in_a  = '0;
    logic [2:0]         sel_a = '0;
    logic [DWA-1:0]     out_a;
    logic [2:0]         cs_a;
    logic               ov_a, wr_a;

    logic [CHB*DWB-1:0] in_b  = '0;
    logic [2:0]         sel_b = '0;
    logic [DWB-1:0]     out_b;
    logic [2:0]         cs_b;
    logic               ov_b, wr_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    scan_mux #(.DATA_WIDTH(DWA), .CHANNELS(CHA), .SCAN_DIV(DIVA)) u_a (
        .clock(clock), .reset(reset), .in_bus(in_a), .select(sel_a), .enable(enable),
        .mode(mode), .hold(hold), .out(out_a), .cur_sel(cs_a), .out_valid(ov_a), .wrap(wr_a)
    );

    scan_mux #(.DATA_WIDTH(DWB), .CHANNELS(CHB), .SCAN_DIV(DIVB)) u_b (
        .clock(clock), .reset(reset), .in_bus(in_b), .select(sel_b), .enable(enable),
        .mode(mode), .hold(hold), .out(out_b), .cur_sel(cs_b), .out_valid(ov_b), .wrap(wr_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DWA-1:0] chan_a(input int k);
        logic [CHA*DWA-1:0] t;
        t = in_a >> (k * DWA);
        return t[DWA-1:0];
    endfunction

    function automatic logic [DWB-1:0] chan_b(input int k);
        logic [CHB*DWB-1:0] t;
        t = in_b >> (k * DWB);
        return t[DWB-1:0];
    endfunction

    // Reference: 'dwell' counts edges the current scan channel has been shown.
    function automatic void mstep(input int nch, input int div, input bit rst, input bit md,
                                  input bit hd, input int sel, inout bit scanning,
                                  inout int pos, inout int dwell, output int idx, output bit wr);
        wr = 1'b0;
        if (rst) begin
            scanning = 1'b0; pos = 0; dwell = 0; idx = 0;
            return;
        end
`ifdef SCAN_MUX_SCAN_EN
        if (md) begin
            if (!scanning) begin
                scanning = 1'b1; pos = 0; dwell = 1;
            end else if (!hd) begin
                if (dwell == div) begin
                    pos   = (pos + 1) % nch;
                    dwell = 1;
                    wr    = (pos == 0);
                end else begin
                    dwell++;
                end
            end
            idx = pos;
            return;
        end
`else
        if (md && hd && div < 0) idx = 0;
`endif
        scanning = 1'b0; dwell = 0; idx = sel;
    endfunction

    bit sc_a, sc_b;
    int pos_a, pos_b, dw_a, dw_b;

    always @(posedge clock) begin
        int ia, ib;
        bit wa, wb, va, vb;
        logic [DWA-1:0] ea;
        logic [DWB-1:0] eb;
        mstep(CHA, DIVA, reset, mode, hold, int'(sel_a), sc_a, pos_a, dw_a, ia, wa);
        mstep(CHB, DIVB, reset, mode, hold, int'(sel_b), sc_b, pos_b, dw_b, ib, wb);
        va = !reset && enable && (ia < CHA);
        vb = !reset && enable && (ib < CHB);
        ea = va ? chan_a(ia) : '0;
        eb = vb ? chan_b(ib) : '0;
        #1;
        chk("a_out", out_a, ea);
        chk("a_cur_sel", cs_a, ia);
        chk("a_valid", ov_a, va);
        chk("a_wrap", wr_a, wa);
        chk("b_out", out_b, eb);
        chk("b_cur_sel", cs_b, ib);
        chk("b_valid", ov_b, vb);
        chk("b_wrap", wr_b, wb);
    end

    task automatic rand_data();
        logic [287:0] tmp;
        for (int i = 0; i < 9; i++) tmp[i*32 +: 32] = $urandom;
        in_a = tmp[CHA*DWA-1:0];
        in_b = tmp[287 -: CHB*DWB];
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        repeat (2) @(negedge clock);

        rand_data();
        in_a[5*DWA +: DWA] = 35'h1_2345_6789;
        in_a[2*DWA +: DWA] = 35'h5_A5A5_A5A5;
        sel_a  = 3'd5;
        sel_b  = 3'd7;
        enable = 1'b1;
        mode   = 1'b0;
        hold   = 1'b0;
        reset  = 1'b0;
        @(posedge clock); #2;
        chk("pin_ch5_out", out_a, 35'h1_2345_6789);
        chk("pin_ch5_sel", cs_a, 5);
        chk("pin_ch5_valid", ov_a, 1);
        chk("pin_oor_out", out_b, 0);
        chk("pin_oor_valid", ov_b, 0);
        chk("pin_oor_sel", cs_b, 7);

`ifdef SCAN_MUX_SCAN_EN
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0; mode = 1'b1;
        for (int n = 0; n <= 45; n++) begin
            @(posedge clock); #2;
            chk("pin_scan_sel", cs_a, (n / 4) % 8);
            chk("pin_scan_wrap", wr_a, (n == 32));
        end
        @(negedge clock); hold = 1'b1;
        repeat (10) begin
            @(posedge clock); #2;
            chk("pin_hold_sel", cs_a, 3);
            chk("pin_hold_wrap", wr_a, 0);
        end
        @(negedge clock); hold = 1'b0;
        for (int r = 1; r <= 3; r++) begin
            @(posedge clock); #2;
            chk("pin_release_sel", cs_a, (r == 3) ? 4 : 3);
        end
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            @(posedge clock); #2;
            if (cs_a == 3'd6) found = 1'b1;
        end
        chk("pin_reach_sel6", cs_a, 6);
        @(negedge clock); reset = 1'b1;
        @(posedge clock); #2;
        chk("pin_rst_out", out_a, 0);
        chk("pin_rst_sel", cs_a, 0);
        chk("pin_rst_valid", ov_a, 0);
        chk("pin_rst_wrap", wr_a, 0);
        @(negedge clock); reset = 1'b0; mode = 1'b0;
`else
        @(negedge clock); mode = 1'b1; hold = 1'b1; sel_a = 3'd2;
        @(posedge clock); #2;
        chk("pin_noscan_out", out_a, 35'h5_A5A5_A5A5);
        chk("pin_noscan_sel", cs_a, 2);
        chk("pin_noscan_wrap", wr_a, 0);
        @(negedge clock); mode = 1'b0; hold = 1'b0;
`endif

        repeat (3000) begin
            @(negedge clock);
            rand_data();
            sel_a  = 3'($urandom_range(0, 7));
            sel_b  = 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 7) != 0);
            hold   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            reset  = ($urandom_range(0, 63) == 0);
        end
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
